// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
// Byte-stream front-end for the 8-bit combinational ALU: gathers opcode and
// operands, then captures the ALU result with zero/sign flags for a consumer.
//
// Handshake rules (both streams):
// - A beat or result moves only on a cycle where valid && ready.
// - The producer holds valid and its data stable until that cycle.
// - ready never depends combinationally on valid.
module alu_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             opc2,
  output logic             opc1,
  output logic             opc0,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  input  logic [7:0]       alu_s,
  output logic             res_valid,
  output logic [7:0]       res_data,
  output logic             res_zero,
  output logic             res_neg,
  input  logic             res_ready,
  output logic [CNT_W-1:0] op_count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    GET_OP = 3'd0,
    GET_A  = 3'd1,
    GET_B  = 3'd2,
    EXEC   = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t     state;
  logic [2:0] opc;
  logic       in_fire;
  logic       unary_a;

  assign {opc2, opc1, opc0} = opc;
  assign state_dbg = state;
  assign in_fire   = in_valid && in_ready;
  // Opcodes 011 and 110 only use operand a, so the b beat is skipped.
  assign unary_a   = (opc == 3'b011) || (opc == 3'b110);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= GET_OP;
      opc       <= 3'b000;
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      res_data  <= 8'h00;
      res_zero  <= 1'b0;
      res_neg   <= 1'b0;
      res_valid <= 1'b0;
      op_count  <= '0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        GET_OP: begin
          if (in_fire) begin
            opc   <= in_data[2:0];
            state <= (in_data[2:0] == 3'b111) ? GET_B : GET_A;
          end
        end
        GET_A: begin
          if (in_fire) begin
            alu_a <= in_data;
            if (unary_a) begin
              state    <= EXEC;
              in_ready <= 1'b0;
            end else begin
              state <= GET_B;
            end
          end
        end
        GET_B: begin
          if (in_fire) begin
            alu_b    <= in_data;
            state    <= EXEC;
            in_ready <= 1'b0;
          end
        end
        EXEC: begin
          // opc and operands have been stable for a full cycle here.
          res_data  <= alu_s;
          res_zero  <= (alu_s == 8'h00);
          res_neg   <= alu_s[7];
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            state     <= GET_OP;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= GET_OP;
          res_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
// Bench for alu_sequencer: a behavioural ALU drives alu_s, a table of known
// vectors plus random operations are checked against a reference model.
module tb_alu_sequencer;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             opc2, opc1, opc0;
  logic [7:0]       alu_a, alu_b, alu_s;
  logic             res_valid;
  logic [7:0]       res_data;
  logic             res_zero, res_neg;
  logic             res_ready;
  logic [CNT_W-1:0] op_count;
  logic [2:0]       state_dbg;
  logic [2:0]       alu_op;

  alu_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .opc2(opc2), .opc1(opc1), .opc0(opc0),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .res_valid(res_valid),
    .res_data(res_data), .res_zero(res_zero), .res_neg(res_neg),
    .res_ready(res_ready), .op_count(op_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // The ALU sitting behind the sequencer.
  assign alu_op = {opc2, opc1, opc0};
  always_comb begin
    alu_s = 8'h00;
    case (alu_op)
      3'b000: alu_s = alu_a | alu_b;
      3'b001: alu_s = alu_a & alu_b;
      3'b010: alu_s = alu_a ^ alu_b;
      3'b011: alu_s = ~alu_a;
      3'b100: alu_s = alu_a + alu_b;
      3'b101: alu_s = alu_a - alu_b;
      3'b110: alu_s = alu_a + 8'd1;
      default: alu_s = alu_b + 8'd1;
    endcase
  end

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_q[$];
  logic [7:0] a_m, b_m;
  logic [2:0] op_m;
  int         cnt_m;
  bit         gap_en;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       zero;
    logic       neg;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [7:0] ref_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0: r = ia | ib;
      3'd1: r = ia & ib;
      3'd2: r = ia ^ ib;
      3'd3: r = 255 - ia;
      3'd4: r = (ia + ib) % 256;
      3'd5: r = (ia - ib + 256) % 256;
      3'd6: r = (ia + 1) % 256;
      default: r = (ib + 1) % 256;
    endcase
    return 8'(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready, 1);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"},  res_data, 0);
    check({tag, "_res_zero"},  res_zero, 0);
    check({tag, "_res_neg"},   res_neg, 0);
    check({tag, "_op_count"},  op_count, 0);
    check({tag, "_opc"},       alu_op, 0);
    check({tag, "_alu_a"},     alu_a, 0);
    check({tag, "_alu_b"},     alu_b, 0);
    check({tag, "_state"},     state_dbg, 0);
  endtask

  task automatic model_reset();
    a_m = 8'h00; b_m = 8'h00; op_m = 3'b000; cnt_m = 0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [7:0] d);
    int n;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    send_beat({5'($urandom_range(0, 31)), op});
    op_m = op;
    if (op != 3'b111) begin
      send_beat(a);
      a_m = a;
    end
    if (op != 3'b011 && op != 3'b110) begin
      send_beat(b);
      b_m = b;
    end
    check("in_ready_exec", in_ready, 0);
    check("res_valid_early", res_valid, 0);
    tick();
    check("res_valid_latency", res_valid, 1);
    r = ref_res(op, a_m, b_m);
    exp_q.push_back({r[7], (r == 8'h00), r});
  endtask

  task automatic collect(input int delay, output logic [7:0] got);
    logic [9:0] e;
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    check("res_valid_wait", res_valid, 1);
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard: result with empty expected queue");
      $fatal(1, "scoreboard");
    end
    e = exp_q.pop_front();
    got = res_data;
    check("res_data", res_data, e[7:0]);
    check("res_zero", res_zero, e[8]);
    check("res_neg",  res_neg,  e[9]);
    check("opc_hold", alu_op, op_m);
    check("alu_a_hold", alu_a, a_m);
    check("alu_b_hold", alu_b, b_m);
    for (int i = 0; i < delay; i++) begin
      res_ready = 1'b0;
      tick();
      check("stall_valid", res_valid, 1);
      check("stall_data", res_data, e[7:0]);
      check("stall_flags", {res_neg, res_zero}, {e[9], e[8]});
      check("stall_in_ready", in_ready, 0);
      check("stall_count", op_count, cnt_m);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    cnt_m = (cnt_m + 1) % 256;
    check("op_count", op_count, cnt_m);
    check("res_valid_clear", res_valid, 0);
    check("in_ready_after", in_ready, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] got;
    logic [2:0] rop;

    vecs[0] = '{3'b000, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b1};
    vecs[1] = '{3'b101, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{3'b100, 8'hFF, 8'h02, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{3'b110, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{3'b111, 8'h00, 8'h7F, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{3'b001, 8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0};
    vecs[6] = '{3'b010, 8'hAA, 8'h0F, 8'hA5, 1'b0, 1'b1};
    vecs[7] = '{3'b011, 8'h5A, 8'h00, 8'hA5, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; res_ready = 1'b0; gap_en = 1'b0;
    model_reset();
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Known vectors; the 110 row precedes 111, so alu_a must stay 0xFF.
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b);
      collect(0, got);
      check("vec_res", got, vecs[i].res);
      check("vec_zero", res_zero, vecs[i].zero);
      check("vec_neg", res_neg, vecs[i].neg);
    end
    check("vec_count", op_count, 8);

    // Result held five cycles, accepted on the sixth.
    run_op(3'b000, 8'h81, 8'h02);
    collect(5, got);

    // Reset while waiting for operand b.
    send_beat(8'h02);
    send_beat(8'h33);
    check("mid_seq_state", state_dbg, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_reset_outputs("rst_get_b");
    run_op(3'b001, 8'h3C, 8'h0F);
    collect(0, got);
    check("after_reset_res", got, 8'h0C);

    // Reset while a result is held.
    run_op(3'b100, 8'h10, 8'h20);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_reset_outputs("rst_hold");

    // 256 back-to-back NOT operations wrap the counter back to zero.
    for (int i = 0; i < 256; i++) begin
      run_op(3'b011, 8'h00, 8'h00);
      collect(0, got);
    end
    check("op_count_wrap", op_count, 0);

    // Random operations with idle gaps and consumer back-pressure.
    gap_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rop = 3'($urandom_range(0, 7));
      run_op(rop, 8'($urandom), 8'($urandom));
      collect($urandom_range(0, 3), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
